// File: rtl/reg_file_pkg.sv
// Shared constants and types for the general-purpose register file.
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

    // Register address for the default-sized file
    typedef logic [DEFAULT_AW-1:0] reg_addr_t;

    // Value every register takes on reset
    localparam int RESET_DATA = 0;

endpackage

// File: rtl/reg_cell.sv
// Single WIDTH-bit register with asynchronous active-low reset and
// active-low write enable.
module reg_cell
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold the stored value; load d when the write enable is low.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= WIDTH'(RESET_DATA);
        end else if (!we_n) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with one write port, two combinational read ports and a
// per-register busy scoreboard (decode reserves, writeback clears).
// Optional macro REG_FILE_BYPASS_EN forwards the write port onto the read
// ports during the write cycle.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_n,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rsv_n,
    input  logic [$clog2(DEPTH)-1:0]   rsv_addr,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_a,
    output logic [WIDTH-1:0]           rd_data_a,
    output logic                       rd_busy_a,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_b,
    output logic [WIDTH-1:0]           rd_data_b,
    output logic                       rd_busy_b,
    output logic [DEPTH-1:0]           busy,
    output logic                       rsv_err
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] rsv_hit;

    // One-hot decode of write and reserve strobes; out-of-range addresses
    // match no register and are therefore ignored.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_hit  = '0;
        rsv_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit[i]  = !wr_n  && (wr_addr  == AW'(i));
            rsv_hit[i] = !rsv_n && (rsv_addr == AW'(i));
        end
    end

    // Storage cells; each is reset so the whole file clears on reset.
    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .we_n  (!wr_hit[g]),
            .d     (wr_data),
            .q     (regs[g])
        );
    end

    // Scoreboard: a write clears busy, a reserve sets it (reserve wins on
    // the same address); the error pulse looks at the pre-edge busy bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q  <= '0;
            rsv_err <= 1'b0;
        end else begin
            busy_q  <= (busy_q & ~wr_hit) | rsv_hit;
            rsv_err <= |(rsv_hit & busy_q);
        end
    end

    assign busy = busy_q;

    // Read muxes; out-of-range read addresses return data 0 and busy 0.
    always_comb begin
        rd_data_a = '0;
        rd_busy_a = 1'b0;
        rd_data_b = '0;
        rd_busy_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == AW'(i)) begin
                rd_data_a = regs[i];
                rd_busy_a = busy_q[i];
            end
            if (rd_addr_b == AW'(i)) begin
                rd_data_b = regs[i];
                rd_busy_b = busy_q[i];
            end
        end
`ifdef REG_FILE_BYPASS_EN
        // An in-range write to the read address forwards its data; the
        // register is shown not busy unless reserved in the same cycle.
        if ((|wr_hit) && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            rd_busy_a = !rsv_n && (rsv_addr == rd_addr_a);
        end
        if ((|wr_hit) && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            rd_busy_b = !rsv_n && (rsv_addr == rd_addr_b);
        end
`endif
    end

endmodule
